bip2_dmem_io: RTL and testbench
===============================

Name: bip2_dmem_io

Overview:
- Responder side of the BIP2 data-memory interface.
- Decodes address, write strobe and write data from the processor; returns read data on the same interface.
- Addresses 0x000-0x3FF map to a data RAM. Addresses 0x400-0x405 map to a small peripheral block: GPIO output, synchronised GPIO input, and a compare timer with a sticky match flag and interrupt line.
- Sits beside the processor top, connected port-for-port to its data-memory interface.

Parameters:
- DATA_W, 11, width of data bus, all registers and RAM words.
- ADDR_W, 11, width of data-memory address.
- RAM_DEPTH, 1024, RAM words; must be ≤ 2^(ADDR_W-1).
- PSC_W, 4, prescaler field width in TMR_CTRL.

Ports:
- CLOCK_i  in  1  system clock, all state on rising edge.
- RESET_i  in  1  asynchronous, active-low reset.
- WRRAM_i  in  1  write strobe from processor; write occurs at rising edge while high.
- ADDR_dm_i  in  ADDR_W  data-memory address.
- IN_DATA_i  in  DATA_W  write data from processor.
- OUT_DATA_o  out  DATA_W  read data to processor; combinational from ADDR_dm_i.
- GPIO_IN_i  in  DATA_W  asynchronous external inputs.
- GPIO_OUT_o  out  DATA_W  GPIO output register.
- TMR_IRQ_o  out  1  level, equals STATUS[0].

Behaviour:
- Reset (RESET_i low, asynchronous):
  - GPIO_OUT, TMR_CTRL, TMR_CNT, TMR_CMP, STATUS, prescaler counter and both GPIO sync stages clear to 0.
  - TMR_IRQ_o = 0.
  - RAM contents are not reset.
  - Reset asserted mid-count aborts the count; no flag is set on release.
- Decode: ADDR_dm_i[ADDR_W-1] = 0 selects RAM at index ADDR_dm_i[9:0]. Otherwise the low 3 bits select the I/O register.
- Read latency is 0 cycles: OUT_DATA_o is an asynchronous mux of the RAM array or register.
- Read of the address being written in the same cycle returns the old value. The new value is visible the cycle after the edge.
- Register map:
  - 0x400 GPIO_OUT: read/write.
  - 0x401 GPIO_IN: read-only, value after 2-flop synchroniser (2-cycle latency).
  - 0x402 TMR_CTRL: read/write. bit0 EN, bit1 AUTO (auto-reload), bits[PSC_W+1:2] PSC, upper bits read 0.
  - 0x403 TMR_CNT: read/write.
  - 0x404 TMR_CMP: read/write.
  - 0x405 STATUS: bit0 MATCH (sticky), bit1 GIN_CHG (sticky, set when the synchronised GPIO_IN differs from its previous value). Write-1-to-clear, upper bits read 0.
  - 0x406-0x7FF: read 0, writes ignored.
- Prescaler: while EN=1, counts 0..PSC and asserts a one-cycle tick when its value equals PSC, then restores 0. PSC=0 gives a tick every cycle. EN=0 holds the prescaler at 0.
- Timer on tick:
  - If CNT == CMP: set MATCH. Then, if AUTO=1, CNT <= 0. If AUTO=0, CNT holds and EN clears (one-shot).
  - Else CNT <= CNT+1, wrapping modulo 2^DATA_W (0x7FF -> 0x000).
- Simultaneous events:
  - CPU write to TMR_CNT or TMR_CTRL in a tick cycle: the CPU value wins and the tick's count update is discarded. A MATCH set from that tick still applies.
  - W1C of a STATUS bit in the same cycle its set condition occurs: set wins, bit stays 1.
  - Writes of 0 bits to STATUS have no effect.
- WRRAM_i with an X/unused address has no side effects beyond the decoded target.

Decomposition:
- Shared package bip2_dmem_pkg holds the address constants: IO_BASE, and register offsets GPIO_OUT, GPIO_IN, TMR_CTRL, TMR_CNT, TMR_CMP, STATUS.
- It also holds the TMR_CTRL bit positions (EN, AUTO, PSC_LSB) and the STATUS bit positions (MATCH, GIN_CHG).
- One sub-module, bip2_timer, contains the prescaler, counter, compare and MATCH set pulse. Its inputs are the CPU write enables and data; its outputs are CNT, the EN-clear pulse and the match pulse.
- Top level holds the RAM, GPIO and decode/read mux.

Test Plan:
- Reset then RAM access: write 0x155 to 0x010, read 0x010 next cycle -> OUT_DATA_o=0x155. Read 0x410 -> 0x000. Reset does not clear RAM at 0x010.
- Write 0x2AA to 0x400 -> GPIO_OUT_o=0x2AA next cycle. Drive GPIO_IN_i=0x0F0 -> read 0x401 returns 0x0F0 after 2 cycles, and STATUS[1]=1. Write STATUS=0x002 -> bit1 clears.
- CMP=3, PSC=0, AUTO=1, EN=1 -> CNT sequence 0,1,2,3,0. TMR_IRQ_o rises on the edge after CNT=3 is evaluated, and stays high until STATUS written with 0x001.
- CMP=2, PSC=2, AUTO=0 -> CNT increments every 3 cycles, MATCH sets at CNT=2, EN reads 0 afterwards, CNT holds 2.
- CNT=0x7FF, CMP=0x005 -> next tick CNT=0x000 (wrap), no MATCH. A CPU write of 0x100 to CNT in a tick cycle -> CNT=0x100.
- Match event and STATUS W1C in the same cycle -> MATCH remains 1. RESET_i low mid-count -> all registers 0 immediately, TMR_IRQ_o=0.

Source files
------------

// File: rtl/bip2_dmem_pkg.sv
// Shared constants for the BIP2 data-memory responder.
// Holds the I/O window base, the peripheral register offsets, the TMR_CTRL
// and STATUS bit positions, and a helper that tells whether an I/O offset
// maps to an implemented register.
package bip2_dmem_pkg;

    localparam logic [10:0] IO_BASE = 11'h400;

    typedef enum logic [2:0] {
        GPIO_OUT = 3'd0,
        GPIO_IN  = 3'd1,
        TMR_CTRL = 3'd2,
        TMR_CNT  = 3'd3,
        TMR_CMP  = 3'd4,
        STATUS   = 3'd5
    } io_reg_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_PSC_LSB = 2;

    localparam int ST_MATCH   = 0;
    localparam int ST_GIN_CHG = 1;

    // Offsets 6 and 7 inside an I/O block are unimplemented.
    function automatic logic io_reg_valid(input logic [2:0] ofs);
        return ofs <= 3'(STATUS);
    endfunction

endpackage

// File: rtl/bip2_timer.sv
// Compare timer: prescaler, up-counter, compare and MATCH set pulse.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_en, i_auto     TMR_CTRL enable and auto-reload bits
//   i_psc            prescaler terminal value
//   i_cmp            compare value
//   i_cnt_we         CPU write to TMR_CNT this cycle (data on i_wdata)
//   i_ctrl_we        CPU write to TMR_CTRL this cycle
//   o_cnt            current count
//   o_en_clr         one-cycle pulse: one-shot match, EN must clear
//   o_match          one-cycle pulse: MATCH must set
module bip2_timer #(
    parameter int DATA_W = 11,
    parameter int PSC_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_auto,
    input  logic [PSC_W-1:0]  i_psc,
    input  logic [DATA_W-1:0] i_cmp,
    input  logic              i_cnt_we,
    input  logic              i_ctrl_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_cnt,
    output logic              o_en_clr,
    output logic              o_match
);

    logic [PSC_W-1:0]  r_psc_cnt;
    logic [DATA_W-1:0] r_cnt;
    logic              w_tick;
    logic              w_hit;

    assign w_tick   = i_en && (r_psc_cnt == i_psc);
    assign w_hit    = w_tick && (r_cnt == i_cmp);
    assign o_match  = w_hit;
    assign o_en_clr = w_hit && !i_auto;
    assign o_cnt    = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_psc_cnt <= '0;
        end else if (!i_en || w_tick) begin
            r_psc_cnt <= '0;
        end else begin
            r_psc_cnt <= r_psc_cnt + 1'b1;
        end
    end

    // A CPU write to CNT or CTRL in a tick cycle discards the tick's count
    // update; the match pulse above is unaffected.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_cnt_we) begin
            r_cnt <= i_wdata;
        end else if (w_tick && !i_ctrl_we) begin
            if (r_cnt == i_cmp) begin
                if (i_auto) begin
                    r_cnt <= '0;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bip2_dmem_io.sv
// Responder side of the BIP2 data-memory interface.
// Lower half of the address space is a data RAM; the upper half holds a small
// peripheral block (GPIO out, synchronised GPIO in, compare timer, STATUS).
// Ports:
//   CLOCK_i     system clock
//   RESET_i     asynchronous active-low reset
//   WRRAM_i     write strobe, write happens at the rising edge while high
//   ADDR_dm_i   data-memory address
//   IN_DATA_i   write data
//   OUT_DATA_o  read data, combinational from ADDR_dm_i
//   GPIO_IN_i   asynchronous external inputs
//   GPIO_OUT_o  GPIO output register
//   TMR_IRQ_o   level interrupt, mirrors STATUS.MATCH
module bip2_dmem_io
    import bip2_dmem_pkg::*;
#(
    parameter int DATA_W    = 11,
    parameter int ADDR_W    = 11,
    parameter int RAM_DEPTH = 1024,
    parameter int PSC_W     = 4
) (
    input  logic              CLOCK_i,
    input  logic              RESET_i,
    input  logic              WRRAM_i,
    input  logic [ADDR_W-1:0] ADDR_dm_i,
    input  logic [DATA_W-1:0] IN_DATA_i,
    output logic [DATA_W-1:0] OUT_DATA_o,
    input  logic [DATA_W-1:0] GPIO_IN_i,
    output logic [DATA_W-1:0] GPIO_OUT_o,
    output logic              TMR_IRQ_o
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int CTRL_W = PSC_W + 2;

    logic [DATA_W-1:0] r_ram [RAM_DEPTH];

    logic [DATA_W-1:0] r_gpio_out;
    logic [DATA_W-1:0] r_gin_s1;
    logic [DATA_W-1:0] r_gin_s2;
    logic [DATA_W-1:0] r_gin_prev;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_cmp;
    logic [1:0]        r_status;

    logic              w_is_io;
    logic              w_io_hit;
    logic [2:0]        w_ofs;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_we_ram;
    logic              w_we_gpio;
    logic              w_we_ctrl;
    logic              w_we_cnt;
    logic              w_we_cmp;
    logic              w_we_status;

    logic [DATA_W-1:0] w_cnt;
    logic              w_en_clr;
    logic              w_match;

    logic [1:0]        w_status_set;
    logic [1:0]        w_status_clr;
    logic [1:0]        w_status_nxt;
    logic [DATA_W-1:0] w_io_rdata;

    // Full decode of the I/O half: anything other than offsets 0..5 of the
    // first block reads 0 and ignores writes, so aliases such as 0x408
    // cannot disturb a register.
    assign w_is_io   = ADDR_dm_i[ADDR_W-1];
    assign w_ofs     = ADDR_dm_i[2:0];
    assign w_io_hit  = w_is_io && (ADDR_dm_i[ADDR_W-2:3] == '0) && io_reg_valid(w_ofs);
    assign w_ram_idx = ADDR_dm_i[RAM_AW-1:0];

    assign w_we_ram    = WRRAM_i && !w_is_io;
    assign w_we_gpio   = WRRAM_i && w_io_hit && (w_ofs == 3'(GPIO_OUT));
    assign w_we_ctrl   = WRRAM_i && w_io_hit && (w_ofs == 3'(TMR_CTRL));
    assign w_we_cnt    = WRRAM_i && w_io_hit && (w_ofs == 3'(TMR_CNT));
    assign w_we_cmp    = WRRAM_i && w_io_hit && (w_ofs == 3'(TMR_CMP));
    assign w_we_status = WRRAM_i && w_io_hit && (w_ofs == 3'(STATUS));

    always_ff @(posedge CLOCK_i) begin
        if (w_we_ram) begin
            r_ram[w_ram_idx] <= IN_DATA_i;
        end
    end

    bip2_timer #(
        .DATA_W (DATA_W),
        .PSC_W  (PSC_W)
    ) u_timer (
        .i_clk     (CLOCK_i),
        .i_rst_n   (RESET_i),
        .i_en      (r_ctrl[CTRL_EN]),
        .i_auto    (r_ctrl[CTRL_AUTO]),
        .i_psc     (r_ctrl[CTRL_PSC_LSB +: PSC_W]),
        .i_cmp     (r_cmp),
        .i_cnt_we  (w_we_cnt),
        .i_ctrl_we (w_we_ctrl),
        .i_wdata   (IN_DATA_i),
        .o_cnt     (w_cnt),
        .o_en_clr  (w_en_clr),
        .o_match   (w_match)
    );

    // Sticky flags: set has priority over a same-cycle write-1-to-clear.
    always_comb begin
        w_status_clr = '0;
        if (w_we_status) begin
            w_status_clr = IN_DATA_i[1:0];
        end
        w_status_set             = '0;
        w_status_set[ST_MATCH]   = w_match;
        w_status_set[ST_GIN_CHG] = (r_gin_s2 != r_gin_prev);
        w_status_nxt = (r_status & ~w_status_clr) | w_status_set;
    end

    always_ff @(posedge CLOCK_i or negedge RESET_i) begin
        if (!RESET_i) begin
            r_gpio_out <= '0;
            r_gin_s1   <= '0;
            r_gin_s2   <= '0;
            r_gin_prev <= '0;
            r_ctrl     <= '0;
            r_cmp      <= '0;
            r_status   <= '0;
        end else begin
            r_gin_s1   <= GPIO_IN_i;
            r_gin_s2   <= r_gin_s1;
            r_gin_prev <= r_gin_s2;
            if (w_we_gpio) begin
                r_gpio_out <= IN_DATA_i;
            end
            if (w_we_cmp) begin
                r_cmp <= IN_DATA_i;
            end
            // CPU write to CTRL beats the one-shot EN clear.
            if (w_we_ctrl) begin
                r_ctrl <= IN_DATA_i[CTRL_W-1:0];
            end else if (w_en_clr) begin
                r_ctrl[CTRL_EN] <= 1'b0;
            end
            r_status <= w_status_nxt;
        end
    end

    always_comb begin
        w_io_rdata = '0;
        case (w_ofs)
            3'(GPIO_OUT): w_io_rdata = r_gpio_out;
            3'(GPIO_IN):  w_io_rdata = r_gin_s2;
            3'(TMR_CTRL): w_io_rdata = DATA_W'(r_ctrl);
            3'(TMR_CNT):  w_io_rdata = w_cnt;
            3'(TMR_CMP):  w_io_rdata = r_cmp;
            3'(STATUS):   w_io_rdata = DATA_W'(r_status);
            default:      w_io_rdata = '0;
        endcase
    end

    assign OUT_DATA_o = w_is_io ? (w_io_hit ? w_io_rdata : '0) : r_ram[w_ram_idx];
    assign GPIO_OUT_o = r_gpio_out;
    assign TMR_IRQ_o  = r_status[ST_MATCH];

endmodule

// File: tb/tb_bip2_dmem_io.sv
module tb_bip2_dmem_io;

    logic        CLOCK_i = 1'b0;
    logic        RESET_i;
    logic        WRRAM_i;
    logic [10:0] ADDR_dm_i;
    logic [10:0] IN_DATA_i;
    logic [10:0] OUT_DATA_o;
    logic [10:0] GPIO_IN_i;
    logic [10:0] GPIO_OUT_o;
    logic        TMR_IRQ_o;

    always #5 CLOCK_i = ~CLOCK_i;

    bip2_dmem_io dut (
        .CLOCK_i    (CLOCK_i),
        .RESET_i    (RESET_i),
        .WRRAM_i    (WRRAM_i),
        .ADDR_dm_i  (ADDR_dm_i),
        .IN_DATA_i  (IN_DATA_i),
        .OUT_DATA_o (OUT_DATA_o),
        .GPIO_IN_i  (GPIO_IN_i),
        .GPIO_OUT_o (GPIO_OUT_o),
        .TMR_IRQ_o  (TMR_IRQ_o)
    );

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [10:0] wdata;
        logic        chk;
        logic [10:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [10:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [10:0] addr, input logic [10:0] wdata,
                       input logic chk, input logic [10:0] exp);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_i);
            #1;
        end
    endtask

    task automatic wr(input logic [10:0] addr, input logic [10:0] data);
        WRRAM_i   = 1'b1;
        ADDR_dm_i = addr;
        IN_DATA_i = data;
        @(posedge CLOCK_i);
        #1;
        WRRAM_i   = 1'b0;
    endtask

    task automatic rd(input logic [10:0] addr, input logic [10:0] exp, input string name);
        ADDR_dm_i = addr;
        sb_q.push_back(exp);
        #1;
        check(name, OUT_DATA_o, sb_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] seq[5];
        logic [10:0] exp_cnt;

        RESET_i   = 1'b1;
        WRRAM_i   = 1'b0;
        ADDR_dm_i = '0;
        IN_DATA_i = '0;
        GPIO_IN_i = '0;
        #3 RESET_i = 1'b0;
        #1;
        check("rst_gpio_out", GPIO_OUT_o, 11'h000);
        check("rst_irq", 11'(TMR_IRQ_o), 11'h000);
        @(posedge CLOCK_i);
        @(posedge CLOCK_i);
        #3 RESET_i = 1'b1;
        step(1);
        for (int i = 0; i < 6; i++) begin
            rd(11'h400 + 11'(i), 11'h000, "rst_reg");
        end

        // Table: RAM, decode, register read/write with the timer disabled.
        add(1, 11'h010, 11'h0AB, 0, 11'h000);
        add(1, 11'h010, 11'h155, 1, 11'h0AB);
        add(0, 11'h010, 11'h000, 1, 11'h155);
        add(0, 11'h410, 11'h000, 1, 11'h000);
        add(1, 11'h400, 11'h2AA, 1, 11'h000);
        add(0, 11'h400, 11'h000, 1, 11'h2AA);
        add(1, 11'h3FF, 11'h7FF, 0, 11'h000);
        add(0, 11'h3FF, 11'h000, 1, 11'h7FF);
        add(1, 11'h008, 11'h0AA, 0, 11'h000);
        add(1, 11'h408, 11'h123, 0, 11'h000);
        add(1, 11'h406, 11'h3FF, 0, 11'h000);
        add(0, 11'h008, 11'h000, 1, 11'h0AA);
        add(0, 11'h400, 11'h000, 1, 11'h2AA);
        add(0, 11'h406, 11'h000, 1, 11'h000);
        add(0, 11'h408, 11'h000, 1, 11'h000);
        add(1, 11'h404, 11'h111, 0, 11'h000);
        add(1, 11'h40C, 11'h7EE, 0, 11'h000);
        add(0, 11'h404, 11'h000, 1, 11'h111);
        add(1, 11'h403, 11'h05A, 0, 11'h000);
        add(0, 11'h403, 11'h000, 1, 11'h05A);
        add(1, 11'h402, 11'h7FC, 0, 11'h000);
        add(0, 11'h402, 11'h000, 1, 11'h03C);
        add(1, 11'h402, 11'h000, 0, 11'h000);
        add(0, 11'h402, 11'h000, 1, 11'h000);
        add(0, 11'h405, 11'h000, 1, 11'h000);
        add(0, 11'h401, 11'h000, 1, 11'h000);

        foreach (tbl[i]) begin
            WRRAM_i   = tbl[i].we;
            ADDR_dm_i = tbl[i].addr;
            IN_DATA_i = tbl[i].wdata;
            if (tbl[i].chk) sb_q.push_back(tbl[i].exp);
            #1;
            if (tbl[i].chk) check($sformatf("tbl[%0d]", i), OUT_DATA_o, sb_q.pop_front());
            @(posedge CLOCK_i);
            #1;
            WRRAM_i = 1'b0;
        end
        check("gpio_out_port", GPIO_OUT_o, 11'h2AA);

        // GPIO input synchroniser and change flag.
        GPIO_IN_i = 11'h0F0;
        step(1);
        rd(11'h401, 11'h000, "gin_1cyc");
        step(1);
        rd(11'h401, 11'h0F0, "gin_2cyc");
        rd(11'h405, 11'h000, "gin_chg_early");
        step(1);
        rd(11'h405, 11'h002, "gin_chg_set");
        wr(11'h405, 11'h000);
        rd(11'h405, 11'h002, "w0_no_effect");
        wr(11'h405, 11'h002);
        rd(11'h405, 11'h000, "gin_chg_w1c");
        GPIO_IN_i = 11'h000;
        step(4);
        wr(11'h405, 11'h002);
        rd(11'h405, 11'h000, "gin_chg_clr2");

        // Auto-reload, PSC=0, CMP=3.
        seq[0] = 11'd0; seq[1] = 11'd1; seq[2] = 11'd2; seq[3] = 11'd3; seq[4] = 11'd0;
        wr(11'h404, 11'h003);
        wr(11'h403, 11'h000);
        wr(11'h402, 11'h003);
        for (int i = 0; i < 5; i++) begin
            rd(11'h403, seq[i], $sformatf("auto_cnt[%0d]", i));
            check($sformatf("auto_irq[%0d]", i), 11'(TMR_IRQ_o), (i == 4) ? 11'h001 : 11'h000);
            step(1);
        end
        check("irq_sticky", 11'(TMR_IRQ_o), 11'h001);
        wr(11'h402, 11'h000);
        check("irq_after_dis", 11'(TMR_IRQ_o), 11'h001);
        wr(11'h405, 11'h001);
        check("irq_w1c", 11'(TMR_IRQ_o), 11'h000);

        // One-shot, PSC=2, CMP=2.
        wr(11'h403, 11'h000);
        wr(11'h404, 11'h002);
        wr(11'h402, 11'h009);
        for (int k = 0; k < 13; k++) begin
            exp_cnt = (k < 3) ? 11'd0 : ((k < 6) ? 11'd1 : 11'd2);
            rd(11'h403, exp_cnt, $sformatf("oneshot_cnt[%0d]", k));
            rd(11'h405, (k >= 9) ? 11'h001 : 11'h000, $sformatf("oneshot_st[%0d]", k));
            step(1);
        end
        rd(11'h402, 11'h008, "oneshot_en_clr");
        wr(11'h405, 11'h001);

        // Wrap, then CPU writes colliding with ticks.
        wr(11'h403, 11'h7FF);
        wr(11'h404, 11'h005);
        wr(11'h402, 11'h003);
        rd(11'h403, 11'h7FF, "wrap_pre");
        step(1);
        rd(11'h403, 11'h000, "wrap_cnt");
        rd(11'h405, 11'h000, "wrap_no_match");
        step(1);
        rd(11'h403, 11'h001, "wrap_next");
        wr(11'h403, 11'h100);
        rd(11'h403, 11'h100, "cnt_wr_wins");
        step(1);
        rd(11'h403, 11'h101, "cnt_after_wr");
        wr(11'h402, 11'h003);
        rd(11'h403, 11'h101, "ctrl_wr_discard");
        step(1);
        rd(11'h403, 11'h102, "cnt_resume");
        wr(11'h402, 11'h000);

        // Match and W1C in the same cycle: set wins.
        wr(11'h403, 11'h003);
        wr(11'h404, 11'h003);
        wr(11'h402, 11'h003);
        wr(11'h405, 11'h001);
        rd(11'h405, 11'h001, "set_beats_w1c");
        rd(11'h403, 11'h000, "match_reload");

        // Reset in the middle of a count.
        wr(11'h400, 11'h155);
        step(2);
        check("pre_rst_irq", 11'(TMR_IRQ_o), 11'h001);
        #2 RESET_i = 1'b0;
        #1;
        check("mid_rst_gpio", GPIO_OUT_o, 11'h000);
        check("mid_rst_irq", 11'(TMR_IRQ_o), 11'h000);
        rd(11'h403, 11'h000, "mid_rst_cnt");
        rd(11'h402, 11'h000, "mid_rst_ctrl");
        rd(11'h404, 11'h000, "mid_rst_cmp");
        rd(11'h405, 11'h000, "mid_rst_status");
        step(1);
        RESET_i = 1'b1;
        step(4);
        rd(11'h403, 11'h000, "post_rst_cnt");
        rd(11'h405, 11'h000, "post_rst_status");
        check("post_rst_irq", 11'(TMR_IRQ_o), 11'h000);
        rd(11'h010, 11'h155, "ram_survives_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
